// File: rtl/mic_test_screen_anim_if.sv
// Pixel request / colour return bus between the OLED driver side and the animated MIC TEST screen.
interface mic_test_screen_anim_if #(
  parameter int unsigned LEVEL_BITS = 12
);
  logic                  enable;
  logic                  frame_begin;
  logic [6:0]            x;
  logic [5:0]            y;
  logic [LEVEL_BITS-1:0] mic_level;
  logic [15:0]           oled_data;
  logic                  anim_done;

  modport master (
    output enable, frame_begin, x, y, mic_level,
    input  oled_data, anim_done
  );

  modport slave (
    input  enable, frame_begin, x, y, mic_level,
    output oled_data, anim_done
  );
endinterface

// File: rtl/mic_test_screen_anim.sv
// Animated MIC TEST screen: slide-in mic icon, blinking caption, live segmented level bar.
module mic_test_screen_anim #(
  parameter int unsigned SCREEN_W     = 96,
  parameter int unsigned SCREEN_H     = 64,
  parameter int unsigned ICON_X       = 27,
  parameter int unsigned ICON_Y       = 21,
  parameter int unsigned SLIDE_STEP   = 2,
  parameter int unsigned BLINK_FRAMES = 15,
  parameter int unsigned BAR_SEGS     = 8,
  parameter int unsigned LEVEL_BITS   = 12,
  parameter logic [15:0] BG           = 16'hFFFF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  mic_test_screen_anim_if.slave bus_io
);
  localparam int unsigned OFF_W  = 8;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned LIT_W  = 4;
  localparam int unsigned PROD_W = LEVEL_BITS + LIT_W;
  localparam int CAP_X = 47, CAP_Y0 = 29, CAP_Y1 = 37, CAP_PITCH = 6;
  localparam int BAR_X0 = 10, BAR_PITCH = 10, BAR_LEN = 8, BAR_Y0 = 50, BAR_Y1 = 55;
  localparam logic [15:0] BLACK = 16'h0000, LIGHTGREEN = 16'hAFE5, DARKGREEN = 16'h632C;
  localparam logic [15:0] GREEN = 16'h07E0, YELLOW = 16'hFFE0, RED = 16'hF800;
  localparam logic [2:0] CH_M = 3'd0, CH_I = 3'd1, CH_C = 3'd2, CH_T = 3'd3, CH_E = 3'd4, CH_S = 3'd5;

  typedef enum logic [1:0] {IDLE = 2'd0, SLIDE = 2'd1, SHOW = 2'd2} state_e;

  state_e                state_q, state_d;
  logic [OFF_W-1:0]      off_q, off_d;
  logic [CNT_W-1:0]      blink_cnt_q, blink_cnt_d;
  logic                  text_on_q, text_on_d;
  logic [LEVEL_BITS-1:0] level_q, level_d;
  logic [15:0]           oled_data_q;
  logic                  anim_done_q;

  logic [8:0]       icon_u_c;
  logic [6:0]       icon_v_c;
  logic             icon_hit_c;
  logic [1:0]       icon_idx_c;
  logic             cap_line_c, cap_line1_c, cap_slot_hit_c, cap_on_c;
  logic [1:0]       cap_slot_c;
  logic [2:0]       cap_row_c, cap_col_c, cap_ch_c;
  logic [4:0]       cap_bits_c;
  logic [LIT_W-1:0] lit_c, seg_idx_c;
  logic             seg_hit_c, bar_on_c;
  logic [15:0]      seg_col_c, pix_c;

  // Mic glyph: capsule with grille, U-shaped holder, stem and base.
  function automatic logic [1:0] icon_rom(input logic [4:0] u, input logic [4:0] v);
    logic [1:0] px;
    px = 2'd0;
    if (v <= 5'd12 && u >= 5'd6 && u <= 5'd13) begin
      if (v == 5'd0 || v == 5'd12 || u == 5'd6 || u == 5'd13) px = 2'd1;
      else if (!v[0] && v <= 5'd8)                             px = 2'd3;
      else                                                     px = 2'd2;
    end else if (v >= 5'd9 && v <= 5'd13 && (u == 5'd3 || u == 5'd16)) px = 2'd1;
    else if (v == 5'd14 && (u == 5'd4 || u == 5'd15))                px = 2'd1;
    else if (v == 5'd15 && u >= 5'd5 && u <= 5'd14)                  px = 2'd1;
    else if (v >= 5'd16 && v <= 5'd20 && u >= 5'd9 && u <= 5'd10)    px = 2'd3;
    else if (v >= 5'd21 && v <= 5'd22 && u >= 5'd4 && u <= 5'd15)    px = 2'd1;
    return px;
  endfunction

  // 5x7 font row, bit 4 is the leftmost column.
  function automatic logic [4:0] font_row(input logic [2:0] ch, input logic [2:0] row);
    logic [34:0] g;
    case (ch)
      CH_M:    g = {5'b10001, 5'b11011, 5'b10101, 5'b10101, 5'b10001, 5'b10001, 5'b10001};
      CH_I:    g = {5'b01110, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b01110};
      CH_C:    g = {5'b01110, 5'b10001, 5'b10000, 5'b10000, 5'b10000, 5'b10001, 5'b01110};
      CH_T:    g = {5'b11111, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b00100};
      CH_E:    g = {5'b11111, 5'b10000, 5'b10000, 5'b11110, 5'b10000, 5'b10000, 5'b11111};
      CH_S:    g = {5'b01111, 5'b10000, 5'b10000, 5'b01110, 5'b00001, 5'b00001, 5'b11110};
      default: g = '0;
    endcase
    return 5'(g >> (5 * (6 - int'(row))));
  endfunction

  // Animation state: slide offset, blink phase, frame-latched level; enable low wins over frame_begin.
  always_comb begin
    state_d     = state_q;
    off_d       = off_q;
    blink_cnt_d = blink_cnt_q;
    text_on_d   = text_on_q;
    level_d     = bus_io.frame_begin ? bus_io.mic_level : level_q;
    if (!bus_io.enable) begin
      state_d     = IDLE;
      off_d       = OFF_W'(SCREEN_W);
      blink_cnt_d = '0;
      text_on_d   = 1'b1;
    end else if (bus_io.frame_begin) begin
      case (state_q)
        IDLE: begin
          state_d = SLIDE;
          off_d   = OFF_W'(SCREEN_W);
        end
        SLIDE: begin
          if (off_q == '0) begin
            state_d     = SHOW;
            blink_cnt_d = '0;
            text_on_d   = 1'b1;
          end else if (off_q > OFF_W'(SLIDE_STEP)) begin
            off_d = off_q - OFF_W'(SLIDE_STEP);
          end else begin
            off_d = '0;
          end
        end
        SHOW: begin
          if (blink_cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
            blink_cnt_d = '0;
            text_on_d   = ~text_on_q;
          end else begin
            blink_cnt_d = blink_cnt_q + CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Icon hit test in signed 9-bit space so off-screen columns never wrap back in.
  assign icon_u_c   = 9'({2'b00, bus_io.x}) - 9'(ICON_X) - {1'b0, off_q};
  assign icon_v_c   = {1'b0, bus_io.y} - 7'(ICON_Y);
  assign icon_hit_c = !icon_u_c[8] && (icon_u_c[7:0] < 8'd20) && !icon_v_c[6] && (icon_v_c[5:0] < 6'd23);
  assign icon_idx_c = icon_hit_c ? icon_rom(icon_u_c[4:0], icon_v_c[4:0]) : 2'd0;

  // Caption lookup: which line, which character slot, which glyph pixel.
  always_comb begin
    cap_line_c     = 1'b0;
    cap_line1_c    = 1'b0;
    cap_row_c      = '0;
    cap_slot_hit_c = 1'b0;
    cap_slot_c     = '0;
    cap_col_c      = '0;
    cap_ch_c       = CH_M;
    if ({1'b0, bus_io.y} >= 7'(CAP_Y0) && {1'b0, bus_io.y} < 7'(CAP_Y0 + 7)) begin
      cap_line_c = 1'b1;
      cap_row_c  = 3'(bus_io.y - 6'(CAP_Y0));
    end else if ({1'b0, bus_io.y} >= 7'(CAP_Y1) && {1'b0, bus_io.y} < 7'(CAP_Y1 + 7)) begin
      cap_line_c  = 1'b1;
      cap_line1_c = 1'b1;
      cap_row_c   = 3'(bus_io.y - 6'(CAP_Y1));
    end
    for (int k = 0; k < 4; k++) begin
      if ({1'b0, bus_io.x} >= 8'(CAP_X + CAP_PITCH * k) && {1'b0, bus_io.x} < 8'(CAP_X + CAP_PITCH * k + 5)) begin
        cap_slot_hit_c = 1'b1;
        cap_slot_c     = 2'(k);
        cap_col_c      = 3'(bus_io.x - 7'(CAP_X + CAP_PITCH * k));
      end
    end
    case ({cap_line1_c, cap_slot_c})
      3'b000:  cap_ch_c = CH_M;
      3'b001:  cap_ch_c = CH_I;
      3'b010:  cap_ch_c = CH_C;
      3'b100:  cap_ch_c = CH_T;
      3'b101:  cap_ch_c = CH_E;
      3'b110:  cap_ch_c = CH_S;
      3'b111:  cap_ch_c = CH_T;
      default: cap_slot_hit_c = 1'b0;
    endcase
  end

  assign cap_bits_c = font_row(cap_ch_c, cap_row_c);
  assign cap_on_c   = (state_q == SHOW) && text_on_q && cap_line_c && cap_slot_hit_c && cap_bits_c[3'd4 - cap_col_c];

  // Level bar: segment under x and its colour band.
  always_comb begin
    seg_hit_c = 1'b0;
    seg_idx_c = '0;
    seg_col_c = RED;
    for (int i = 0; i < int'(BAR_SEGS); i++) begin
      if ({1'b0, bus_io.x} >= 8'(BAR_X0 + BAR_PITCH * i) && {1'b0, bus_io.x} <= 8'(BAR_X0 + BAR_PITCH * i + BAR_LEN - 1)) begin
        seg_hit_c = 1'b1;
        seg_idx_c = LIT_W'(i);
        if (i < int'(BAR_SEGS / 2))       seg_col_c = GREEN;
        else if (i < int'(BAR_SEGS) - 1)  seg_col_c = YELLOW;
        else                              seg_col_c = RED;
      end
    end
  end

  assign lit_c    = LIT_W'((PROD_W'(level_q) * PROD_W'(BAR_SEGS)) >> LEVEL_BITS);
  assign bar_on_c = seg_hit_c && (seg_idx_c < lit_c) &&
                    {1'b0, bus_io.y} >= 7'(BAR_Y0) && {1'b0, bus_io.y} <= 7'(BAR_Y1);

  // Pixel priority: icon > caption > bar > background; nothing outside the screen or in IDLE.
  always_comb begin
    pix_c = BG;
    if (state_q != IDLE && {1'b0, bus_io.x} < 8'(SCREEN_W) && {1'b0, bus_io.y} < 7'(SCREEN_H)) begin
      case (icon_idx_c)
        2'd1:    pix_c = BLACK;
        2'd2:    pix_c = LIGHTGREEN;
        2'd3:    pix_c = DARKGREEN;
        default: begin
          if (cap_on_c)      pix_c = BLACK;
          else if (bar_on_c) pix_c = seg_col_c;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      off_q       <= OFF_W'(SCREEN_W);
      blink_cnt_q <= '0;
      text_on_q   <= 1'b1;
      level_q     <= '0;
      oled_data_q <= BG;
      anim_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      off_q       <= off_d;
      blink_cnt_q <= blink_cnt_d;
      text_on_q   <= text_on_d;
      level_q     <= level_d;
      oled_data_q <= pix_c;
      anim_done_q <= (state_d == SHOW);
    end
  end

  assign bus_io.oled_data = oled_data_q;
  assign bus_io.anim_done = anim_done_q;
endmodule

// File: tb/tb_mic_test_screen_anim.sv
// Scoreboard bench for mic_test_screen_anim against a frame-counting reference model.
module tb_mic_test_screen_anim;
  logic clk = 1'b0;
  logic rst_i;

  mic_test_screen_anim_if #(.LEVEL_BITS(12)) bus ();

  mic_test_screen_anim dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .bus_io(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          x;
    int          y;
    logic [15:0] pix;
    bit          done;
    int          tag;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;
  int   tag_cnt  = 0;

  // Reference model: phase 0 idle, 1 slide, 2 show; positions derived from frame counts.
  int m_phase   = 0;
  int m_slide_n = 0;
  int m_show_n  = 0;
  int m_level   = 0;

  string icon_art [0:22];
  string font_art [0:5][0:6];

  initial begin
    icon_art = '{
      "......KKKKKKKK......", "......KLLLLLLK......", "......KDDDDDDK......",
      "......KLLLLLLK......", "......KDDDDDDK......", "......KLLLLLLK......",
      "......KDDDDDDK......", "......KLLLLLLK......", "......KDDDDDDK......",
      "...K..KLLLLLLK..K...", "...K..KLLLLLLK..K...", "...K..KLLLLLLK..K...",
      "...K..KKKKKKKK..K...", "...K............K...", "....K..........K....",
      ".....KKKKKKKKKK.....", ".........DD.........", ".........DD.........",
      ".........DD.........", ".........DD.........", ".........DD.........",
      "....KKKKKKKKKKKK....", "....KKKKKKKKKKKK...."
    };
    font_art = '{
      '{"#...#", "##.##", "#.#.#", "#.#.#", "#...#", "#...#", "#...#"},
      '{".###.", "..#..", "..#..", "..#..", "..#..", "..#..", ".###."},
      '{".###.", "#...#", "#....", "#....", "#....", "#...#", ".###."},
      '{"#####", "..#..", "..#..", "..#..", "..#..", "..#..", "..#.."},
      '{"#####", "#....", "#....", "####.", "#....", "#....", "#####"},
      '{".####", "#....", "#....", ".###.", "....#", "....#", "####."}
    };
  end

  function automatic int m_off();
    return (2 * m_slide_n >= 96) ? 0 : 96 - 2 * m_slide_n;
  endfunction

  function automatic bit glyph_on(input byte ch, input int r, input int c);
    int idx;
    case (ch)
      "M":     idx = 0;
      "I":     idx = 1;
      "C":     idx = 2;
      "T":     idx = 3;
      "E":     idx = 4;
      default: idx = 5;
    endcase
    return font_art[idx][r][c] == "#";
  endfunction

  function automatic logic [15:0] exp_pix(input int x, input int y);
    int    u, v, lit;
    byte   c;
    string words [0:1];
    int    wy [0:1];
    words = '{"MIC", "TEST"};
    wy    = '{29, 37};
    if (x >= 96 || y >= 64 || m_phase == 0) return 16'hFFFF;
    u = x - 27 - m_off();
    v = y - 21;
    if (u >= 0 && u < 20 && v >= 0 && v < 23) begin
      c = icon_art[v][u];
      if (c == "K") return 16'h0000;
      if (c == "L") return 16'hAFE5;
      if (c == "D") return 16'h632C;
    end
    if (m_phase == 2 && ((m_show_n / 15) % 2) == 0) begin
      for (int w = 0; w < 2; w++) begin
        for (int k = 0; k < words[w].len(); k++) begin
          if (x >= 47 + 6 * k && x < 52 + 6 * k && y >= wy[w] && y < wy[w] + 7)
            if (glyph_on(words[w][k], y - wy[w], x - (47 + 6 * k))) return 16'h0000;
        end
      end
    end
    lit = (m_level * 8) / 4096;
    if (y >= 50 && y <= 55) begin
      for (int i = 0; i < 8; i++) begin
        if (x >= 10 + 10 * i && x <= 17 + 10 * i && i < lit) begin
          if (i < 4) return 16'h07E0;
          if (i < 7) return 16'hFFE0;
          return 16'hF800;
        end
      end
    end
    return 16'hFFFF;
  endfunction

  task automatic m_advance(input bit en, input bit fb, input int lvl);
    if (fb) m_level = lvl;
    if (!en) begin
      m_phase   = 0;
      m_slide_n = 0;
      m_show_n  = 0;
    end else if (fb) begin
      case (m_phase)
        0: begin m_phase = 1; m_slide_n = 0; end
        1: begin
          if (m_off() == 0) begin m_phase = 2; m_show_n = 0; end
          else m_slide_n++;
        end
        default: m_show_n++;
      endcase
    end
  endtask

  // One clock of stimulus; expected colour uses the model state before this cycle's update.
  task automatic step(input bit rst, input bit en, input bit fb, input int lvl, input int px, input int py);
    exp_t e;
    @(negedge clk);
    rst_i           = rst;
    bus.enable      = en;
    bus.frame_begin = fb;
    bus.mic_level   = 12'(lvl);
    bus.x           = 7'(px);
    bus.y           = 6'(py);
    e.x   = px;
    e.y   = py;
    e.tag = tag_cnt++;
    if (rst) begin
      m_phase = 0; m_slide_n = 0; m_show_n = 0; m_level = 0;
      e.pix  = 16'hFFFF;
      e.done = 1'b0;
    end else begin
      e.pix = exp_pix(px, py);
      m_advance(en, fb, lvl);
      e.done = (m_phase == 2);
    end
    sb_q.push_back(e);
  endtask

  task automatic rand_px(output int px, output int py);
    case ($urandom_range(0, 3))
      0: begin px = $urandom_range(0, 127); py = $urandom_range(0, 63); end
      1: begin px = $urandom_range(24, 127); py = $urandom_range(20, 44); end
      2: begin px = $urandom_range(45, 72);  py = $urandom_range(28, 44); end
      default: begin px = $urandom_range(8, 92); py = $urandom_range(49, 56); end
    endcase
  endtask

  task automatic frame(input bit en, input int lvl, input int npix);
    int px, py;
    rand_px(px, py);
    step(0, en, 1, lvl, px, py);
    repeat (npix) begin
      rand_px(px, py);
      step(0, en, 0, $urandom_range(0, 4095), px, py);
    end
  endtask

  // Monitor: one registered pixel per cycle, compared against the oldest expectation.
  always @(posedge clk) begin
    #2;
    if (sb_q.size() != 0) begin
      mon_e = sb_q.pop_front();
      n_checks++;
      if (bus.oled_data !== mon_e.pix) begin
        n_errors++;
        $display("FAIL oled_data #%0d (%0d,%0d): got %h expected %h", mon_e.tag, mon_e.x, mon_e.y, bus.oled_data, mon_e.pix);
      end
      n_checks++;
      if (bus.anim_done !== mon_e.done) begin
        n_errors++;
        $display("FAIL anim_done #%0d: got %b expected %b", mon_e.tag, bus.anim_done, mon_e.done);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, expected finish before timeout");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int px, py;
    rst_i           = 1'b1;
    bus.enable      = 1'b0;
    bus.frame_begin = 1'b0;
    bus.mic_level   = '0;
    bus.x           = '0;
    bus.y           = '0;

    step(1, 0, 0, 0, 5, 5);
    step(1, 1, 0, 0, 30, 30);

    // Enabled but no frame yet: everything background.
    repeat (16) begin
      rand_px(px, py);
      step(0, 1, 0, $urandom_range(0, 4095), px, py);
    end

    // Slide-in across 50 frames, probing the icon's final origin each frame.
    for (int f = 0; f < 50; f++) begin
      step(0, 1, 1, $urandom_range(0, 4095), 27, 21);
      step(0, 1, 0, $urandom_range(0, 4095), 36, 30);
      step(0, 1, 0, $urandom_range(0, 4095), 27 + $urandom_range(0, 19), 21 + $urandom_range(0, 22));
      repeat (3) begin
        rand_px(px, py);
        step(0, 1, 0, $urandom_range(0, 4095), px, py);
      end
    end

    // Caption blink over 32 frames.
    for (int f = 0; f < 32; f++) begin
      step(0, 1, 1, $urandom_range(0, 4095), 48, 30);
      step(0, 1, 0, $urandom_range(0, 4095), 48, 30);
      step(0, 1, 0, $urandom_range(0, 4095), 47 + $urandom_range(0, 22), 37 + $urandom_range(0, 6));
      rand_px(px, py);
      step(0, 1, 0, $urandom_range(0, 4095), px, py);
    end

    // Full-scale level and segment edges.
    step(0, 1, 1, 4095, 0, 0);
    step(0, 1, 0, 4095, 80, 52);
    step(0, 1, 0, 4095, 70, 52);
    step(0, 1, 0, 4095, 11, 52);
    step(0, 1, 0, 4095, 17, 50);
    step(0, 1, 0, 4095, 18, 55);
    step(0, 1, 0, 4095, 77, 49);
    step(0, 1, 0, 4095, 40, 56);

    // Level changes between frames must not move the bar.
    step(0, 1, 1, 12'h200, 11, 52);
    step(0, 1, 0, 12'hFFF, 11, 52);
    step(0, 1, 0, 12'hFFF, 21, 52);
    step(0, 1, 0, 12'hFFF, 61, 53);
    step(0, 1, 1, 12'hA00, 21, 52);
    step(0, 1, 0, 12'h000, 51, 52);
    step(0, 1, 0, 12'h000, 51, 52);

    // Restart, then drop enable together with frame_begin mid-slide.
    step(0, 0, 0, 0, 40, 52);
    step(0, 1, 1, 12'hC00, 40, 52);
    for (int f = 0; f < 10; f++) frame(1, $urandom_range(0, 4095), 2);
    step(0, 0, 1, 12'hFFF, 11, 52);
    step(0, 1, 0, 12'hFFF, 11, 52);
    step(0, 1, 0, 12'hFFF, 90, 30);
    step(0, 1, 1, 12'hFFF, 11, 52);
    step(0, 1, 0, 12'hFFF, 11, 52);

    // Randomized long run with occasional enable drops.
    for (int f = 0; f < 260; f++) begin
      frame(($urandom_range(0, 79) != 0), $urandom_range(0, 4095), $urandom_range(1, 4));
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
